mem_io_arbiter: RTL and testbench
=================================

// Module: mem_io_arbiter
// PURPOSE
//  Shares one data-memory port and the memory-mapped I/O space (KEY, SW, HEX, LEDR, LEDG) between two
//  requesters: m0 = processor data port, m1 = debug/loader port. Round-robin arbitration, one transaction
//  per grant. Sits between the datapath's LW/SW path and the synchronous data memory; owns the I/O registers.
// PARAMETERS
//  DBITS         32           data/address width
//  DMEMADDRBITS  13           byte-address bits covered by data memory (addr[31:13]==0 selects DMEM)
//  DMEMWORDBITS  2            byte-offset bits dropped to form the word address
//  ADDR_HEX      32'hF0000000 HEX register (RW, low 16 bits)
//  ADDR_LEDR     32'hF0000004 LEDR register (RW, low 10 bits)
//  ADDR_LEDG     32'hF0000008 LEDG register (RW, low 8 bits)
//  ADDR_KEY      32'hF0000010 KEY status (RO)
//  ADDR_SW       32'hF0000014 SW status (RO)
// PORTS
//  clk           in  1      system clock (PLL c0)
//  reset         in  1      asynchronous, active-low; block held in reset while reset==0
//  m{0,1}_req    in  1      transaction request; held with addr/we/wdata stable until ack
//  m{0,1}_we     in  1      1 = write, 0 = read
//  m{0,1}_addr   in  DBITS  byte address
//  m{0,1}_wdata  in  DBITS  write data
//  m{0,1}_ack    out 1      one-cycle completion pulse
//  m{0,1}_rdata  out DBITS  read data, valid only while own ack==1
//  dmem_addr     out DMEMADDRBITS-DMEMWORDBITS  word address to data memory
//  dmem_we       out 1      data-memory write strobe
//  dmem_wdata    out DBITS  data-memory write data
//  dmem_rdata    in  DBITS  data-memory read data, one cycle after dmem_addr (synchronous RAM)
//  key_in        in  4      raw KEY pins, active-low
//  sw_in         in  10     raw SW pins
//  hex_out       out 16     four hex digits (top level decodes to HEX0..HEX3)
//  ledr_out      out 10     LEDR drive
//  ledg_out      out 8      LEDG drive
//  bus_err       out 1      one-cycle pulse: unmapped or misaligned access completed
// BEHAVIOUR
//  Reset: state IDLE, all acks/dmem_we/bus_err 0, rdata 0, hex/ledr/ledg 0, last_grant=1, synchronizers 0.
//  FSM IDLE -> ACCESS -> (write: IDLE | read: RESP -> IDLE).
//   IDLE: if any req, pick winner, latch its addr/we/wdata/id, update last_grant, go ACCESS.
//   ACCESS: decode latched addr. DMEM: drive dmem_addr; dmem_we=we. I/O write: update register.
//     Write: assert winner ack this cycle, go IDLE. Read: go RESP.
//   RESP: winner rdata = DMEM ? dmem_rdata : I/O value; assert ack; go IDLE.
//  Latency from req sampled in IDLE: write ack 2nd cycle after, read ack 3rd cycle after.
//  Requester drops req on the edge where it sees ack=1; req high in a later IDLE is a new transaction.
//  Arbitration: only one req -> it wins. Both -> grant != last_grant; last_grant reset 1 so m0 wins first tie.
//  Loser's req stays pending; no request starved (each waits at most one foreign transaction).
//  Decode: misaligned (addr[1:0]!=0) or matching no region -> write dropped, read returns 0,
//   ack still given, bus_err pulses with ack. Sub-word widths: write keeps low bits, read zero-extends.
//  KEY read = {28'b0, ~key_sync}; SW read = {22'b0, sw_sync}; both 2-FF synchronized to clk.
//  RO writes (KEY/SW) -> dropped, bus_err pulses.
//  dmem_we high only in ACCESS of a mapped DMEM write; dmem_addr holds last value otherwise.
//  Reset mid-transaction: abort to IDLE, no ack, no further writes; already-committed writes stay.
// STRUCTURE
//  Package mem_io_pkg: ADDR_* constants, DMEM bit widths, state enum {IDLE, ACCESS, RESP}, region enum
//   {REG_DMEM, REG_HEX, REG_LEDR, REG_LEDG, REG_KEY, REG_SW, REG_NONE}.
//  Sub-module io_sync (2-FF synchronizer, WIDTH parameter, async active-low reset) for key_in and sw_in.
//  Arbiter, FSM, decoder and I/O registers stay in this module.
// TESTING
//  m0 write 0x1234 to 0xF0000000 -> m0_ack 2nd cycle after req, hex_out=16'h1234, dmem_we stays 0.
//  m1 write 0xDEADBEEF to 0x100, then read 0x100 -> dmem_addr=0x40, m1_rdata=0xDEADBEEF with ack.
//  m0 and m1 req same cycle, both reads -> m0 acked first, m1 acked next; repeat tie -> m1 wins first.
//  key_in=4'b1110, sw_in=10'h2A5 held 3 cycles; read 0xF0000010 -> 0x1, read 0xF0000014 -> 0x2A5.
//  Write 0xF0000020 and read 0x00000102 -> ack+bus_err each, rdata 0, no register/dmem change.
//  reset low during ACCESS of a LEDR write -> no ack, ledr_out=0 after release, FSM in IDLE.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants and enums for the memory / memory-mapped I/O arbiter.
package mem_io_pkg;

  localparam int DATA_BITS       = 32;
  localparam int DMEM_ADDR_BITS  = 13;
  localparam int DMEM_WORD_BITS  = 2;
  localparam int DMEM_WADDR_BITS = DMEM_ADDR_BITS - DMEM_WORD_BITS;

  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    REG_DMEM = 3'd0,
    REG_HEX  = 3'd1,
    REG_LEDR = 3'd2,
    REG_LEDG = 3'd3,
    REG_KEY  = 3'd4,
    REG_SW   = 3'd5,
    REG_NONE = 3'd6
  } region_e;

endpackage

// File: rtl/io_sync.sv
// Two-flop synchronizer for slow asynchronous board inputs (KEY, SW).
module io_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mem_io_arbiter.sv
// Round-robin arbiter sharing the synchronous data memory and the memory-mapped
// I/O registers (HEX, LEDR, LEDG, KEY, SW) between the CPU (m0) and debug (m1) ports.
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int DBITS        = DATA_BITS,
  parameter int DMEMADDRBITS = DMEM_ADDR_BITS,
  parameter int DMEMWORDBITS = DMEM_WORD_BITS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 m0_req,
  input  logic                                 m0_we,
  input  logic [DBITS-1:0]                     m0_addr,
  input  logic [DBITS-1:0]                     m0_wdata,
  output logic                                 m0_ack,
  output logic [DBITS-1:0]                     m0_rdata,
  input  logic                                 m1_req,
  input  logic                                 m1_we,
  input  logic [DBITS-1:0]                     m1_addr,
  input  logic [DBITS-1:0]                     m1_wdata,
  output logic                                 m1_ack,
  output logic [DBITS-1:0]                     m1_rdata,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dmem_addr,
  output logic                                 dmem_we,
  output logic [DBITS-1:0]                     dmem_wdata,
  input  logic [DBITS-1:0]                     dmem_rdata,
  input  logic [3:0]                           key_in,
  input  logic [9:0]                           sw_in,
  output logic [15:0]                          hex_out,
  output logic [9:0]                           ledr_out,
  output logic [7:0]                           ledg_out,
  output logic                                 bus_err,
  output logic [1:0]                           dbg_state
);

  // Handshake: a requester raises req with addr/we/wdata and holds them stable
  // until its one-cycle ack; it drops req on the edge where it sees ack high.

  localparam int WA = DMEMADDRBITS - DMEMWORDBITS;

  state_e           state_q, state_d;
  region_e          region_q, region_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic [DBITS-1:0] wdata_q, wdata_d;
  logic [WA-1:0]    dmem_addr_q, dmem_addr_d;
  logic [15:0]      hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;

  logic [3:0]       key_sync;
  logic [9:0]       sw_sync;

  logic             win;
  logic [DBITS-1:0] win_addr;
  region_e          win_region;
  logic             ack;
  logic [DBITS-1:0] rdata;

  io_sync #(.WIDTH(4)) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_in),
    .q     (key_sync)
  );

  io_sync #(.WIDTH(10)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sw_sync)
  );

  function automatic region_e decode(input logic [DBITS-1:0] a);
    region_e r;
    r = REG_NONE;
    if (a[DMEMWORDBITS-1:0] != '0)          r = REG_NONE;
    else if (a[DBITS-1:DMEMADDRBITS] == '0) r = REG_DMEM;
    else if (a == ADDR_HEX)                 r = REG_HEX;
    else if (a == ADDR_LEDR)                r = REG_LEDR;
    else if (a == ADDR_LEDG)                r = REG_LEDG;
    else if (a == ADDR_KEY)                 r = REG_KEY;
    else if (a == ADDR_SW)                  r = REG_SW;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    dmem_addr_d  = dmem_addr_q;
    hex_d        = hex_q;
    ledr_d       = ledr_q;
    ledg_d       = ledg_q;
    ack          = 1'b0;
    rdata        = '0;
    bus_err      = 1'b0;
    dmem_we      = 1'b0;

    // On a tie the port that did not win last time gets the grant.
    if (m0_req && m1_req) win = ~last_grant_q;
    else                  win = m1_req;
    win_addr   = win ? m1_addr : m0_addr;
    win_region = decode(win_addr);

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = ACCESS;
          last_grant_d = win;
          id_d         = win;
          we_d         = win ? m1_we : m0_we;
          wdata_d      = win ? m1_wdata : m0_wdata;
          region_d     = win_region;
          // dmem_addr only moves for DMEM accesses so the RAM sees it during ACCESS.
          if (win_region == REG_DMEM) dmem_addr_d = win_addr[DMEMADDRBITS-1:DMEMWORDBITS];
        end
      end
      ACCESS: begin
        if (we_q) begin
          ack     = 1'b1;
          state_d = IDLE;
          case (region_q)
            REG_DMEM: dmem_we = 1'b1;
            REG_HEX:  hex_d   = wdata_q[15:0];
            REG_LEDR: ledr_d  = wdata_q[9:0];
            REG_LEDG: ledg_d  = wdata_q[7:0];
            default:  bus_err = 1'b1;
          endcase
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        ack     = 1'b1;
        state_d = IDLE;
        case (region_q)
          REG_DMEM: rdata   = dmem_rdata;
          REG_HEX:  rdata   = {{(DBITS-16){1'b0}}, hex_q};
          REG_LEDR: rdata   = {{(DBITS-10){1'b0}}, ledr_q};
          REG_LEDG: rdata   = {{(DBITS-8){1'b0}}, ledg_q};
          REG_KEY:  rdata   = {{(DBITS-4){1'b0}}, ~key_sync};
          REG_SW:   rdata   = {{(DBITS-10){1'b0}}, sw_sync};
          default:  bus_err = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      region_q     <= REG_NONE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      dmem_addr_q  <= '0;
      hex_q        <= '0;
      ledr_q       <= '0;
      ledg_q       <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      dmem_addr_q  <= dmem_addr_d;
      hex_q        <= hex_d;
      ledr_q       <= ledr_d;
      ledg_q       <= ledg_d;
    end
  end

  assign m0_ack     = ack & ~id_q;
  assign m1_ack     = ack & id_q;
  assign m0_rdata   = m0_ack ? rdata : '0;
  assign m1_rdata   = m1_ack ? rdata : '0;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = wdata_q;
  assign hex_out    = hex_q;
  assign ledr_out   = ledr_q;
  assign ledg_out   = ledg_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Self-checking bench for mem_io_arbiter with a synchronous RAM model and per-port scoreboards.
module tb_mem_io_arbiter;
  import mem_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [10:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic [7:0]  ledg_out;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dmem_we_cnt = 0;
  int ack_cnt  = 0;

  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  logic [31:0] mem [0:2047];

  mem_io_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_ack     (m0_ack),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_ack     (m1_ack),
    .m1_rdata   (m1_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .key_in     (key_in),
    .sw_in      (sw_in),
    .hex_out    (hex_out),
    .ledr_out   (ledr_out),
    .ledg_out   (ledg_out),
    .bus_err    (bus_err),
    .dbg_state  (dbg_state)
  );

  // Clock, cycle counter, event counters and RAM model.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (dmem_we) dmem_we_cnt++;
    if (m0_ack || m1_ack) ack_cnt++;
  end

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= mem[dmem_addr];
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "global timeout");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One transaction on port id; expected {bus_err, rdata} is pushed on issue and popped on ack.
  task automatic master_txn(input bit id, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [32:0] exp,
                            output int lat, output int ack_cyc);
    logic [32:0] got;
    logic [32:0] want;
    bit seen;
    seen = 1'b0;
    lat = 0;
    ack_cyc = -1;
    @(negedge clk);
    if (id == 1'b0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      exp0_q.push_back(exp);
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      exp1_q.push_back(exp);
    end
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if ((id == 1'b0) ? m0_ack : m1_ack) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ack_timeout_m%0d addr=%h got=no_ack required=ack", id, addr);
      want = (id == 1'b0) ? exp0_q.pop_front() : exp1_q.pop_front();
    end else begin
      ack_cyc = cyc;
      got  = (id == 1'b0) ? {bus_err, m0_rdata} : {bus_err, m1_rdata};
      want = (id == 1'b0) ? exp0_q.pop_front() : exp1_q.pop_front();
      if (we ? (got[32] !== want[32]) : (got !== want)) begin
        failures++;
        $display("FAIL sb_m%0d addr=%h we=%0b got=%h required=%h", id, addr, we, got, want);
      end
    end
    if (id == 1'b0) m0_req = 1'b0;
    else            m1_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    key_in = 4'hF; sw_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m0_ack, m1_ack, dmem_we, bus_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b required=0000", {m0_ack, m1_ack, dmem_we, bus_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h required=0", m0_rdata, m1_rdata);
    end
    checks++;
    if ({hex_out, ledr_out, ledg_out} !== 34'h0) begin
      failures++;
      $display("FAIL reset_io got=%h/%h/%h required=0", hex_out, ledr_out, ledg_out);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_hex_write();
    int lat, ac, w0;
    wait_cycles(2);
    w0 = dmem_we_cnt;
    master_txn(1'b0, 1'b1, 32'hF000_0000, 32'h0000_1234, {1'b0, 32'h0}, lat, ac);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL hex_write_latency got=%0d required=1", lat);
    end
    @(posedge clk); #1;
    checks++;
    if (hex_out !== 16'h1234) begin
      failures++;
      $display("FAIL hex_out got=%h required=1234", hex_out);
    end
    checks++;
    if (dmem_we_cnt !== w0) begin
      failures++;
      $display("FAIL hex_dmem_we got=%0d required=%0d", dmem_we_cnt, w0);
    end
  endtask

  task automatic test_dmem();
    int lat, ac, w0;
    wait_cycles(2);
    w0 = dmem_we_cnt;
    master_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, {1'b0, 32'h0}, lat, ac);
    checks++;
    if (dmem_addr !== 11'h040) begin
      failures++;
      $display("FAIL dmem_addr_wr got=%h required=040", dmem_addr);
    end
    wait_cycles(2);
    checks++;
    if (dmem_we_cnt !== w0 + 1) begin
      failures++;
      $display("FAIL dmem_we_count got=%0d required=%0d", dmem_we_cnt, w0 + 1);
    end
    master_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, {1'b0, 32'hDEAD_BEEF}, lat, ac);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL read_latency got=%0d required=2", lat);
    end
  endtask

  task automatic test_tie();
    int l0, l1, c0, c1;
    wait_cycles(2);
    fork
      master_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, {1'b0, 32'hDEAD_BEEF}, l0, c0);
      master_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, {1'b0, 32'h0000_1234}, l1, c1);
    join
    checks++;
    if (!(c0 < c1)) begin
      failures++;
      $display("FAIL tie1_order got=m0@%0d,m1@%0d required=m0_first", c0, c1);
    end
    // A solo m0 grant leaves m0 as last winner, so the next tie goes to m1.
    master_txn(1'b0, 1'b0, 32'hF000_0004, 32'h0, {1'b0, 32'h0}, l0, c0);
    wait_cycles(2);
    fork
      master_txn(1'b0, 1'b0, 32'hF000_0000, 32'h0, {1'b0, 32'h0000_1234}, l0, c0);
      master_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, {1'b0, 32'hDEAD_BEEF}, l1, c1);
    join
    checks++;
    if (!(c1 < c0)) begin
      failures++;
      $display("FAIL tie2_order got=m0@%0d,m1@%0d required=m1_first", c0, c1);
    end
  endtask

  task automatic test_io();
    int lat, ac;
    key_in = 4'b1110;
    sw_in  = 10'h2A5;
    wait_cycles(3);
    master_txn(1'b0, 1'b0, 32'hF000_0010, 32'h0, {1'b0, 32'h0000_0001}, lat, ac);
    master_txn(1'b1, 1'b0, 32'hF000_0014, 32'h0, {1'b0, 32'h0000_02A5}, lat, ac);
    master_txn(1'b0, 1'b1, 32'hF000_0008, 32'hFFFF_FFFF, {1'b0, 32'h0}, lat, ac);
    master_txn(1'b1, 1'b1, 32'hF000_0004, 32'hFFFF_FFFF, {1'b0, 32'h0}, lat, ac);
    @(posedge clk); #1;
    checks++;
    if ({ledg_out, ledr_out} !== {8'hFF, 10'h3FF}) begin
      failures++;
      $display("FAIL subword_write got=%h/%h required=ff/3ff", ledg_out, ledr_out);
    end
    master_txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, {1'b0, 32'h0000_00FF}, lat, ac);
    master_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, {1'b0, 32'h0000_03FF}, lat, ac);
  endtask

  task automatic test_bus_err();
    int lat, ac, w0;
    logic [15:0] h;
    logic [9:0]  r;
    logic [7:0]  g;
    logic [10:0] a;
    h = hex_out; r = ledr_out; g = ledg_out; a = dmem_addr; w0 = dmem_we_cnt;
    master_txn(1'b0, 1'b1, 32'hF000_0020, 32'h5555_5555, {1'b1, 32'h0}, lat, ac);
    master_txn(1'b1, 1'b0, 32'h0000_0102, 32'h0, {1'b1, 32'h0}, lat, ac);
    master_txn(1'b0, 1'b1, 32'hF000_0010, 32'h0000_000F, {1'b1, 32'h0}, lat, ac);
    master_txn(1'b1, 1'b1, 32'h0000_0101, 32'h1111_1111, {1'b1, 32'h0}, lat, ac);
    wait_cycles(2);
    checks++;
    if ({hex_out, ledr_out, ledg_out} !== {h, r, g}) begin
      failures++;
      $display("FAIL err_regs got=%h/%h/%h required=%h/%h/%h", hex_out, ledr_out, ledg_out, h, r, g);
    end
    checks++;
    if (dmem_we_cnt !== w0 || dmem_addr !== a) begin
      failures++;
      $display("FAIL err_dmem got=we%0d,addr%h required=we%0d,addr%h", dmem_we_cnt, dmem_addr, w0, a);
    end
    master_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, {1'b0, 32'hDEAD_BEEF}, lat, ac);
  endtask

  task automatic test_back_to_back();
    int lat, ac;
    logic [31:0] data [6];
    bit          who  [6];
    for (int i = 0; i < 6; i++) begin
      data[i] = $urandom();
      who[i]  = 1'($urandom_range(0, 1));
      master_txn(who[i], 1'b1, 32'h0000_0200 + 32'(i * 4), data[i], {1'b0, 32'h0}, lat, ac);
    end
    for (int i = 0; i < 6; i++) begin
      master_txn(~who[i], 1'b0, 32'h0000_0200 + 32'(i * 4), 32'h0, {1'b0, data[i]}, lat, ac);
    end
  endtask

  task automatic test_reset_abort();
    int lat, ac, a0;
    bit acked;
    wait_cycles(2);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hF000_0004; m0_wdata = 32'h0000_0155;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ACCESS) begin
      failures++;
      $display("FAIL abort_in_access got=%0d required=%0d", dbg_state, ACCESS);
    end
    a0 = ack_cnt;
    reset = 1'b0;
    #1;
    acked = m0_ack;
    repeat (2) begin
      @(posedge clk); #1;
      acked |= m0_ack;
    end
    @(negedge clk);
    m0_req = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (acked || ack_cnt !== a0) begin
      failures++;
      $display("FAIL abort_ack got=acked%0b,cnt%0d required=none,cnt%0d", acked, ack_cnt, a0);
    end
    checks++;
    if (ledr_out !== 10'h0) begin
      failures++;
      $display("FAIL abort_ledr got=%h required=000", ledr_out);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL abort_state got=%0d required=%0d", dbg_state, IDLE);
    end
    master_txn(1'b0, 1'b1, 32'hF000_0004, 32'h0000_02AA, {1'b0, 32'h0}, lat, ac);
    @(posedge clk); #1;
    checks++;
    if (ledr_out !== 10'h2AA) begin
      failures++;
      $display("FAIL post_abort_ledr got=%h required=2aa", ledr_out);
    end
  endtask

  initial begin
    test_reset();
    test_hex_write();
    test_dmem();
    test_tie();
    test_io();
    test_bus_err();
    test_back_to_back();
    test_reset_abort();
    wait_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
